// File: rtl/cnt_seq_pkg.sv
// Shared definitions for the counter sequencing arbiter: command codes,
// FSM state codes and default widths.
package cnt_seq_pkg;

    localparam int DEF_DW = 8;
    localparam int DEF_LW = 4;

    // Command encodings carried on cmd0/cmd1
    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_UP   = 2'b01;
    localparam logic [1:0] CMD_DOWN = 2'b10;
    localparam logic [1:0] CMD_NOP  = 2'b11;

    // Sequencer FSM states
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/cnt_seq_arbiter_rr_arb2.sv
// Two-way arbiter with a combinational grant and a registered fairness pointer.
// Optional macro CNT_SEQ_ARB_FIXED_PRIO_EN: fixed priority (req[0] always wins),
// no pointer register.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic       take,    // the current grant is being consumed this cycle
    output logic [1:0] gnt
);

`ifdef CNT_SEQ_ARB_FIXED_PRIO_EN
    assign gnt[0] = req[0];
    assign gnt[1] = req[1] & ~req[0];

    logic unused_ok;
    assign unused_ok = clk ^ reset_n ^ take;
`else
    logic ptr;  // 0: favour req[0] on a tie, 1: favour req[1]

    // A lone request always wins; the pointer only breaks ties.
    assign gnt[0] = req[0] & (~req[1] | ~ptr);
    assign gnt[1] = req[1] & (~req[0] |  ptr);

    // After granting requester i, favour the other one next time.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= 1'b0;
        end else if (take) begin
            ptr <= gnt[0];
        end
    end
`endif

endmodule

// File: rtl/cnt_seq_arbiter.sv
// Sequencer sharing an up/down loadable counter between two requesters.
// Optional macro CNT_SEQ_ARB_FIXED_PRIO_EN selects fixed priority (req0 wins).
//
// Handshake: a requester raises reqN with cmdN/lenN/dN stable and holds them
// until it sees the one-cycle gntN pulse, then drops reqN. Requests are only
// sampled while idle. doneN pulses for one cycle when the command completes.
module cnt_seq_arbiter
    import cnt_seq_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int LW = DEF_LW
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          req0,
    input  logic          req1,
    input  logic [1:0]    cmd0,
    input  logic [1:0]    cmd1,
    input  logic [LW-1:0] len0,
    input  logic [LW-1:0] len1,
    input  logic [DW-1:0] d0,
    input  logic [DW-1:0] d1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic          busy,
    output logic          owner,
    output logic          cnt_en,
    output logic          cnt_load,
    output logic          cnt_inc,
    output logic [DW-1:0] cnt_d,
    output logic [1:0]    dbg_state
);

    logic [1:0]    state;
    logic [1:0]    cap_cmd;
    logic [LW-1:0] rem;

    logic [1:0]    arb_gnt;
    logic          take;
    logic          win;
    logic [1:0]    sel_cmd;
    logic [LW-1:0] sel_len;
    logic [DW-1:0] sel_d;
    logic          skip;

    assign take = (state == ST_IDLE) && (req0 || req1);

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     ({req1, req0}),
        .take    (take),
        .gnt     (arb_gnt)
    );

    // Winner selection and whether the command has no counter work at all
    assign win     = arb_gnt[1];
    assign sel_cmd = win ? cmd1 : cmd0;
    assign sel_len = win ? len1 : len0;
    assign sel_d   = win ? d1   : d0;
    assign skip    = (sel_cmd == CMD_NOP) || ((sel_cmd != CMD_LOAD) && (sel_len == '0));

    assign dbg_state = state;

    // Sequencer FSM: every output is a register so the first control cycle
    // lands together with the grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cap_cmd  <= CMD_NOP;
            rem      <= '0;
            gnt0     <= 1'b0;
            gnt1     <= 1'b0;
            done0    <= 1'b0;
            done1    <= 1'b0;
            busy     <= 1'b0;
            owner    <= 1'b0;
            cnt_en   <= 1'b0;
            cnt_load <= 1'b0;
            cnt_inc  <= 1'b0;
            cnt_d    <= '0;
        end else begin
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (take) begin
                        cap_cmd <= sel_cmd;
                        rem     <= sel_len;
                        owner   <= win;
                        gnt0    <= ~win;
                        gnt1    <= win;
                        busy    <= 1'b1;
                        if (skip) begin
                            state <= ST_DONE;
                        end else begin
                            state    <= ST_EXEC;
                            cnt_en   <= 1'b1;
                            cnt_load <= (sel_cmd == CMD_LOAD);
                            cnt_inc  <= (sel_cmd == CMD_UP);
                            if (sel_cmd == CMD_LOAD) begin
                                cnt_d <= sel_d;
                            end
                        end
                    end
                end
                ST_EXEC: begin
                    rem <= rem - LW'(1);
                    if ((cap_cmd == CMD_LOAD) || (rem == LW'(1))) begin
                        state    <= ST_DONE;
                        cnt_en   <= 1'b0;
                        cnt_load <= 1'b0;
                        cnt_inc  <= 1'b0;
                        done0    <= ~owner;
                        done1    <= owner;
                    end
                end
                ST_DONE: begin
                    // Arriving from EXEC the done pulse is already out; a
                    // skipped command spends one extra cycle here to issue it.
                    if (done0 || done1) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        done0 <= ~owner;
                        done1 <= owner;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnt_seq_arbiter.sv
// Testbench for cnt_seq_arbiter: directed steps plus randomized commands,
// checked against a cycle-timeline model and an arithmetic counter model.
module tb_cnt_seq_arbiter;
    import cnt_seq_pkg::*;

    localparam int DW = 8;
    localparam int LW = 4;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [1:0]    cmd0 = CMD_NOP, cmd1 = CMD_NOP;
    logic [LW-1:0] len0 = '0, len1 = '0;
    logic [DW-1:0] d0 = '0, d1 = '0;
    logic          gnt0, gnt1, done0, done1, busy, owner;
    logic          cnt_en, cnt_load, cnt_inc;
    logic [DW-1:0] cnt_d;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    cnt_seq_arbiter #(.DW(DW), .LW(LW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req0      (req0),
        .req1      (req1),
        .cmd0      (cmd0),
        .cmd1      (cmd1),
        .len0      (len0),
        .len1      (len1),
        .d0        (d0),
        .d1        (d1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .done0     (done0),
        .done1     (done1),
        .busy      (busy),
        .owner     (owner),
        .cnt_en    (cnt_en),
        .cnt_load  (cnt_load),
        .cnt_inc   (cnt_inc),
        .cnt_d     (cnt_d),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard / model state ----------------
    int            tests = 0;
    int            fails = 0;
    logic [DW-1:0] exp_q[$];       // expected counter value after each command
    logic [1:0]    r_cmd[2];
    logic [LW-1:0] r_len[2];
    logic [DW-1:0] r_d[2];
    logic [1:0]    pend = 2'b00;   // requesters still holding req (not yet granted)
    int            fav = 0;        // requester favoured on a tie
    logic [DW-1:0] ctr = '0;       // model of the external counter
    logic [DW-1:0] last_d = '0;    // last value presented on cnt_d

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        check(tag, {gnt0, gnt1, done0, done1, busy, owner, cnt_en, cnt_load, cnt_inc, cnt_d}, 0);
    endtask

    function automatic int pick(input logic [1:0] m);
`ifdef CNT_SEQ_ARB_FIXED_PRIO_EN
        return m[0] ? 0 : 1;
`else
        if (m == 2'b11) return fav;
        return m[0] ? 0 : 1;
`endif
    endfunction

    // Present the requests in mask m and follow the granted command to IDLE.
    task automatic run_cmd(input logic [1:0] m);
        int            w, nx, total;
        logic [1:0]    c;
        logic [LW-1:0] n;
        logic [DW-1:0] dv;
        logic          e_en, e_done;
        w  = pick(m);
        c  = r_cmd[w];
        n  = r_len[w];
        dv = r_d[w];
        if (c == CMD_LOAD)                       nx = 1;
        else if ((c == CMD_NOP) || (n == '0))    nx = 0;
        else                                     nx = int'(n);
        total = (nx == 0) ? 3 : nx + 2;
        case (c)
            CMD_LOAD: exp_q.push_back(dv);
            CMD_UP:   exp_q.push_back(ctr + DW'(n));
            CMD_DOWN: exp_q.push_back(ctr - DW'(n));
            default:  exp_q.push_back(ctr);
        endcase
        req0 = m[0]; cmd0 = r_cmd[0]; len0 = r_len[0]; d0 = r_d[0];
        req1 = m[1]; cmd1 = r_cmd[1]; len1 = r_len[1]; d1 = r_d[1];
        for (int k = 1; k <= total; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                if (w == 0) req0 = 1'b0; else req1 = 1'b0;
                if (c == CMD_LOAD) last_d = dv;
            end
            e_en   = (k <= nx);
            e_done = (nx == 0) ? (k == 2) : (k == nx + 1);
            check("gnt_win",   w ? gnt1 : gnt0, (k == 1));
            check("gnt_lose",  w ? gnt0 : gnt1, 0);
            check("done_win",  w ? done1 : done0, e_done);
            check("done_lose", w ? done0 : done1, 0);
            check("busy",      busy, (k < total));
            check("cnt_en",    cnt_en, e_en);
            check("cnt_load",  cnt_load, e_en && (c == CMD_LOAD));
            check("cnt_inc",   cnt_inc, e_en && (c == CMD_UP));
            check("owner",     owner, w);
            check("cnt_d",     cnt_d, last_d);
            if (cnt_en) begin
                if (cnt_load)     ctr = cnt_d;
                else if (cnt_inc) ctr = ctr + 8'd1;
                else              ctr = ctr - 8'd1;
            end
        end
        check("ctr_final", ctr, exp_q.pop_front());
        fav  = 1 - w;
        pend = m;
        pend[w] = 1'b0;
    endtask

    task automatic drain();
        for (int g = 0; g < 3 && pend != 2'b00; g++) run_cmd(pend);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        logic [1:0] nm;
        r_cmd[0] = CMD_NOP; r_len[0] = '0; r_d[0] = '0;
        r_cmd[1] = CMD_NOP; r_len[1] = '0; r_d[1] = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_outputs");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_zero("post_reset_outputs");

        // LOAD 0x5A from requester 0
        r_cmd[0] = CMD_LOAD; r_d[0] = 8'h5A; r_len[0] = 4'd7;
        run_cmd(2'b01);

        // UP 3 from requester 1
        r_cmd[1] = CMD_UP; r_len[1] = 4'd3;
        run_cmd(2'b10);
        check("ctr_5d", ctr, 8'h5D);

        // Two simultaneous request rounds
        r_cmd[0] = CMD_UP;   r_len[0] = 4'd2;
        r_cmd[1] = CMD_DOWN; r_len[1] = 4'd1;
        run_cmd(2'b11);
        check("tie1_owner", owner, 0);
        r_cmd[0] = CMD_LOAD; r_d[0] = 8'h11;
        run_cmd(pend | 2'b01);
`ifdef CNT_SEQ_ARB_FIXED_PRIO_EN
        check("tie2_owner", owner, 0);
`else
        check("tie2_owner", owner, 1);
`endif
        drain();

        // DOWN len=0 and NOP: no counter activity
        r_cmd[0] = CMD_DOWN; r_len[0] = 4'd0;
        run_cmd(2'b01);
        r_cmd[1] = CMD_NOP;  r_len[1] = 4'd9;
        run_cmd(2'b10);

        // DOWN 15 from 0x00 wraps to 0xF1
        r_cmd[0] = CMD_LOAD; r_d[0] = 8'h00;
        run_cmd(2'b01);
        r_cmd[1] = CMD_DOWN; r_len[1] = 4'd15;
        run_cmd(2'b10);
        check("ctr_f1", ctr, 8'hF1);

        // Reset in the second EXEC cycle of UP 5 from requester 0
        r_cmd[0] = CMD_UP; r_len[0] = 4'd5;
        req0 = 1'b1; cmd0 = r_cmd[0]; len0 = r_len[0];
        @(posedge clk);
        #1;
        check("abort_gnt", gnt0, 1);
        check("abort_en1", cnt_en, 1);
        req0 = 1'b0;
        ctr = ctr + 8'd1;
        @(posedge clk);
        #1;
        check("abort_en2", cnt_en, 1);
        reset_n = 1'b0;
        #1;
        check_zero("abort_outputs");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_zero("abort_hold");
        end
        @(negedge clk);
        reset_n = 1'b1;
        fav = 0;
        last_d = '0;
        @(posedge clk);
        #1;
        check_zero("abort_release");
        check("abort_ctr", ctr, 8'hF2);
        // Pointer is back to favouring requester 0
        r_cmd[0] = CMD_LOAD; r_d[0] = 8'h33;
        r_cmd[1] = CMD_UP;   r_len[1] = 4'd2;
        run_cmd(2'b11);
        check("reset_ptr_owner", owner, 0);
        drain();

        // Randomized command mix
        for (int i = 0; i < 30; i++) begin
            nm = 2'($urandom_range(1, 3));
            for (int j = 0; j < 2; j++) begin
                if (nm[j] && !pend[j]) begin
                    r_cmd[j] = 2'($urandom_range(0, 3));
                    r_len[j] = LW'($urandom_range(0, 15));
                    r_d[j]   = DW'($urandom);
                end
            end
            run_cmd(pend | nm);
        end
        drain();
        check("drained", pend, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cnt_seq_arbiter.md
# cnt_seq_arbiter

Controller that owns the 8-bit up/down loadable counter and shares it between two requesters. Each requester posts one command: load a value, or count up/down N steps. The block arbitrates round-robin, sequences the counter's `load`/`inc` controls plus a count enable for exactly the commanded number of cycles, and reports completion. It sits between software-facing command sources and the counter datapath. The counter itself has no hold state, so the count enable produced here is mandatory.

## Interface
Parameters:
- `DW`, 8: counter data width.
- `LW`, 4: step-length field width; maximum burst is 2^LW−1 steps.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req0`, `req1`  in  1  request levels; each is held until the matching `gnt` is seen, then dropped.
- `cmd0`, `cmd1`  in  2  command: 00 LOAD, 01 UP, 10 DOWN, 11 NOP (reserved).
- `len0`, `len1`  in  LW  number of UP/DOWN steps; ignored for LOAD.
- `d0`, `d1`  in  DW  load value; ignored unless the command is LOAD.
- `gnt0`, `gnt1`  out  1  one-cycle pulse: command captured.
- `done0`, `done1`  out  1  one-cycle pulse: command finished.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `owner`  out  1  index of the current or last granted requester.
- `cnt_en`  out  1  counter clock-enable; the counter advances only when this is high.
- `cnt_load`, `cnt_inc`  out  1  counter control inputs.
- `cnt_d`  out  DW  counter load data.

## Operation
- All outputs are registered. Reset value of every output is 0; the round-robin pointer resets to favour `req0`.
- FSM states:
  - **IDLE**
    - No request: stay in IDLE.
    - Any request present: arbitrate.
      - Capture the winner's cmd/len/d.
      - Pulse its `gnt`.
      - Set `owner`.
      - Go to EXEC, or go straight to DONE if the command is NOP or UP/DOWN with `len`=0.
  - **EXEC**
    - `cnt_en`=1.
    - LOAD: `cnt_load`=1, `cnt_d`=captured data. Lasts 1 cycle.
    - UP: `cnt_load`=0, `cnt_inc`=1.
    - DOWN: `cnt_load`=0, `cnt_inc`=0.
    - Remaining-step counter `rem` is loaded with `len` and decrements each EXEC cycle. The FSM leaves for DONE after the cycle in which `rem`=1.
  - **DONE**
    - `cnt_en`=`cnt_load`=`cnt_inc`=0.
    - Pulse the owner's `done`.
    - Go to IDLE.
- Arbitration:
  - Round-robin. After a grant to requester i, the pointer favours requester 1−i.
  - A lone request is always granted regardless of the pointer.
- Requests are sampled only in IDLE. Requests arriving during EXEC/DONE wait.
- `cnt_d` holds its last value when not loading.
- Reset asserted mid-command:
  - All state clears immediately: IDLE, outputs 0, pointer back to `req0`.
  - No `done` is issued for the aborted command.

## Timing
- Request seen in IDLE in cycle t: `gnt`, `busy`, and the first EXEC control cycle are all in t+1.
- LOAD: `done` in t+2. The counter holds d after the t+1 edge.
- UP/DOWN with len=N≥1: EXEC occupies cycles t+1..t+N, `done` in t+N+1, IDLE in t+N+2.
- len=0 or NOP: `gnt` in t+1 (state DONE), `done` in t+2. The counter is untouched.
- The minimum command-to-command spacing is 3 cycles.
- Simultaneous `req0` and `req1` in IDLE: only the pointer-favoured requester is granted. The other is granted at the next IDLE.

## Configuration
- `CNT_SEQ_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority, `req0` always beats `req1`.
  - The pointer register is not implemented.
- Undefined (default): round-robin as above.

## Structure
- Shared package `cnt_seq_pkg` holds:
  - the command encodings (CMD_LOAD, CMD_UP, CMD_DOWN, CMD_NOP);
  - the FSM state encodings (IDLE, EXEC, DONE);
  - default widths.
- One sub-module, `rr_arb2`:
  - 2-way combinational grant with registered pointer update;
  - degenerates to fixed priority under the macro.

## Test plan
- Reset, then `req0` LOAD d=0x5A → `gnt0` at t+1 with `cnt_load`=1, `cnt_d`=0x5A, `cnt_en`=1; `done0` at t+2; `busy` low at t+3.
- `req1` UP len=3 → `cnt_en`=1, `cnt_inc`=1 for exactly 3 cycles; `done1` at t+4; the counter model advances from 0x5A to 0x5D.
- `req0` and `req1` asserted together twice in a row → grants go 0 then 1; with `CNT_SEQ_ARB_FIXED_PRIO_EN` defined, both grants go to 0.
- DOWN len=0 and a NOP → `gnt` at t+1, `done` at t+2, `cnt_en` never asserted.
- DOWN len=15 from 0x00 → 15 enabled cycles with `cnt_inc`=0; wrap-around to 0xF1 is checked against the counter model.
- `reset_n` pulled low in the 2nd EXEC cycle of UP len=5 → all outputs 0 at once, no `done`; after release, an immediate `req1` is granted in favour of requester 0's pointer default only if `req0` is also present.
